// File: rtl/branch_predictor.sv
// Bimodal branch predictor: 2-bit saturating counters indexed by PC,
// branch condition resolution from ALU flags, and misprediction stats.
module branch_predictor #(
  parameter int INDEX_BITS = 4,
  parameter int PC_WIDTH   = 16,
  parameter int CNT_WIDTH  = 16
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [PC_WIDTH-1:0]  fetch_pc,
  output logic                 predict_taken,
  input  logic                 resolve_valid,
  input  logic [PC_WIDTH-1:0]  resolve_pc,
  input  logic [1:0]           resolve_op,
  input  logic                 resolve_pred,
  input  logic                 zf,
  input  logic                 sf,
  input  logic                 of,
  output logic                 actual_taken,
  output logic                 mispredict,
  output logic [CNT_WIDTH-1:0] mispredict_count
);

  localparam int ENTRIES = 1 << INDEX_BITS;

  localparam logic [1:0] OP_BEQZ = 2'b00;
  localparam logic [1:0] OP_BNEZ = 2'b01;
  localparam logic [1:0] OP_BLTZ = 2'b10;
  localparam logic [1:0] OP_BGEZ = 2'b11;

  logic [1:0]           r_table [ENTRIES];
  logic [CNT_WIDTH-1:0] r_count;

  logic [INDEX_BITS-1:0] w_fidx;
  logic [INDEX_BITS-1:0] w_ridx;
  logic                  w_lt;
  logic                  w_cond;
  logic [1:0]            w_entry;
  logic                  w_unused;

  // Halfword-aligned PCs: bit 0 never selects an entry.
  assign w_fidx = fetch_pc[INDEX_BITS:1];
  assign w_ridx = resolve_pc[INDEX_BITS:1];
  assign w_unused = ^{fetch_pc[PC_WIDTH-1:INDEX_BITS+1], fetch_pc[0],
                      resolve_pc[PC_WIDTH-1:INDEX_BITS+1], resolve_pc[0]};

  assign w_lt = sf ^ of;

  always_comb begin
    w_cond = 1'b0;
    case (resolve_op)
      OP_BEQZ: w_cond = zf;
      OP_BNEZ: w_cond = ~zf;
      OP_BLTZ: w_cond = w_lt;
      OP_BGEZ: w_cond = ~w_lt;
      default: w_cond = 1'b0;
    endcase
  end

  assign actual_taken  = resolve_valid & w_cond;
  assign mispredict    = resolve_valid & (actual_taken != resolve_pred);
  assign predict_taken = r_table[w_fidx][1];
  assign w_entry       = r_table[w_ridx];
  assign mispredict_count = r_count;

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < ENTRIES; i++) begin
        r_table[i] <= 2'b01;
      end
      r_count <= '0;
    end else begin
      if (resolve_valid) begin
        if (actual_taken && (w_entry != 2'b11)) begin
          r_table[w_ridx] <= w_entry + 2'd1;
        end else if (!actual_taken && (w_entry != 2'b00)) begin
          r_table[w_ridx] <= w_entry - 2'd1;
        end
      end
      if (mispredict && (r_count != {CNT_WIDTH{1'b1}})) begin
        r_count <= r_count + CNT_WIDTH'(1);
      end
    end
  end

endmodule

// File: tb/tb_branch_predictor.sv
// Self-checking bench for branch_predictor: directed plan plus random
// traffic checked against an integer-counter reference model.
module tb_branch_predictor;

  localparam int IB   = 4;
  localparam int PW   = 16;
  localparam int CW   = 4;
  localparam int MAXC = (1 << CW) - 1;
  localparam int NENT = 1 << IB;

  logic          clk = 1'b0;
  logic          rst;
  logic [PW-1:0] fetch_pc;
  logic          predict_taken;
  logic          resolve_valid;
  logic [PW-1:0] resolve_pc;
  logic [1:0]    resolve_op;
  logic          resolve_pred;
  logic          zf, sf, of;
  logic          actual_taken;
  logic          mispredict;
  logic [CW-1:0] mispredict_count;

  always #5 clk = ~clk;

  branch_predictor #(
    .INDEX_BITS(IB), .PC_WIDTH(PW), .CNT_WIDTH(CW)
  ) dut (
    .clk(clk), .rst(rst),
    .fetch_pc(fetch_pc), .predict_taken(predict_taken),
    .resolve_valid(resolve_valid), .resolve_pc(resolve_pc),
    .resolve_op(resolve_op), .resolve_pred(resolve_pred),
    .zf(zf), .sf(sf), .of(of),
    .actual_taken(actual_taken), .mispredict(mispredict),
    .mispredict_count(mispredict_count)
  );

  int n_checks = 0;
  int n_fail   = 0;
  int m_tab [NENT];
  int m_cnt;

  task automatic check(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%0h exp=%0h t=%0t", tag, got, exp, $time);
    end
  endtask

  function automatic int bidx(input int pc);
    return (pc >> 1) % NENT;
  endfunction

  function automatic bit m_taken(input int op, input bit z, s, o);
    bit lt;
    lt = (s != o);
    case (op)
      0: return z;
      1: return !z;
      2: return lt;
      default: return !lt;
    endcase
  endfunction

  task automatic m_reset();
    for (int i = 0; i < NENT; i++) m_tab[i] = 1;
    m_cnt = 0;
  endtask

  task automatic cycle(input bit r, v, input int pc, op,
                       input bit pr, z, s, o, input int fpc,
                       output bit g_pt, output bit g_at);
    bit at, mis;
    int k;
    rst = r; resolve_valid = v; resolve_pc = pc[PW-1:0];
    resolve_op = op[1:0]; resolve_pred = pr;
    zf = z; sf = s; of = o; fetch_pc = fpc[PW-1:0];
    #1;
    at  = v && m_taken(op, z, s, o);
    mis = v && (at != pr);
    check("predict", {31'd0, predict_taken}, {31'd0, m_tab[bidx(fpc)] >= 2});
    check("actual", {31'd0, actual_taken}, {31'd0, at});
    check("mispredict", {31'd0, mispredict}, {31'd0, mis});
    check("count", {28'd0, mispredict_count}, m_cnt);
    g_pt = predict_taken;
    g_at = actual_taken;
    @(posedge clk);
    if (r) begin
      m_reset();
    end else if (v) begin
      k = bidx(pc);
      if (at) m_tab[k] = (m_tab[k] == 3) ? 3 : m_tab[k] + 1;
      else    m_tab[k] = (m_tab[k] == 0) ? 0 : m_tab[k] - 1;
      if (mis && m_cnt < MAXC) m_cnt++;
    end
    @(negedge clk);
  endtask

  task automatic idle(input int fpc, output bit g_pt);
    bit d;
    cycle(0, 0, 0, 0, 0, 0, 0, 0, fpc, g_pt, d);
  endtask

  bit pt, at;
  bit exp_dec [4][4];
  bit fz [4], fs [4], fo [4];

  initial begin
    exp_dec[0] = '{1, 0, 0, 0};
    exp_dec[1] = '{0, 1, 1, 1};
    exp_dec[2] = '{0, 1, 0, 1};
    exp_dec[3] = '{1, 0, 1, 0};
    fz = '{1, 0, 0, 0};
    fs = '{0, 1, 1, 0};
    fo = '{0, 0, 1, 1};

    rst = 1'b1; resolve_valid = 1'b0; resolve_pc = '0; resolve_op = '0;
    resolve_pred = 1'b0; zf = 1'b0; sf = 1'b0; of = 1'b0; fetch_pc = '0;
    @(posedge clk);
    m_reset();
    @(negedge clk);

    // Reset state sweep
    for (int a = 0; a <= 'h1E; a += 2) begin
      idle(a, pt);
      check("rst_pred", {31'd0, pt}, 32'd0);
    end
    check("rst_count", {28'd0, mispredict_count}, 32'd0);

    // Training and saturation at 0x0004
    for (int i = 0; i < 3; i++) begin
      cycle(0, 1, 'h4, 0, 0, 1, 0, 0, 'h4, pt, at);
      check("train_pred", {31'd0, pt}, (i == 0) ? 32'd0 : 32'd1);
    end
    idle('h4, pt);
    check("train_sat_pred", {31'd0, pt}, 32'd1);
    check("train_count", {28'd0, mispredict_count}, 32'd3);

    // Condition decode
    for (int op = 0; op < 4; op++) begin
      for (int p = 0; p < 4; p++) begin
        cycle(0, 1, 'h10, op, 0, fz[p], fs[p], fo[p], 0, pt, at);
        check($sformatf("decode_op%0d_p%0d", op, p),
              {31'd0, at}, {31'd0, exp_dec[op][p]});
      end
    end

    // Collision, aliasing, neighbour isolation
    cycle(1, 0, 0, 0, 0, 0, 0, 0, 0, pt, at);
    cycle(0, 1, 'h6, 0, 0, 1, 0, 0, 'h6, pt, at);
    check("collide_same", {31'd0, pt}, 32'd0);
    idle('h6, pt);
    check("collide_next", {31'd0, pt}, 32'd1);
    idle('h26, pt);
    check("alias", {31'd0, pt}, 32'd1);
    cycle(0, 1, 'h8, 0, 0, 0, 0, 0, 'h8, pt, at);
    cycle(0, 1, 'h8, 0, 0, 0, 0, 0, 'h8, pt, at);
    cycle(0, 1, 'h8, 0, 0, 0, 0, 0, 'h8, pt, at);
    idle('h6, pt);
    check("neigh_6", {31'd0, pt}, 32'd1);
    idle('hA, pt);
    check("neigh_A", {31'd0, pt}, 32'd0);
    cycle(0, 1, 'h8, 0, 0, 1, 0, 0, 'h8, pt, at);
    idle('h8, pt);
    check("floor_then_up", {31'd0, pt}, 32'd0);

    // Reset with a concurrent mispredicting resolve
    cycle(1, 1, 'hC, 0, 0, 1, 0, 0, 'hC, pt, at);
    idle('hC, pt);
    check("rst_mid_pred", {31'd0, pt}, 32'd0);
    check("rst_mid_count", {28'd0, mispredict_count}, 32'd0);
    idle('h6, pt);
    check("rst_mid_entry6", {31'd0, pt}, 32'd0);

    // Statistics counter saturation
    for (int i = 0; i < 17; i++) begin
      cycle(0, 1, 2 * i, 1, 1, 1, 0, 0, 0, pt, at);
    end
    idle(0, pt);
    check("count_sat", {28'd0, mispredict_count}, MAXC);

    // Random traffic
    for (int i = 0; i < 600; i++) begin
      cycle(($urandom_range(0, 49) == 0), $urandom_range(0, 3) != 0,
            $urandom_range(0, 'hFFFF), $urandom_range(0, 3),
            $urandom_range(0, 1), $urandom_range(0, 1),
            $urandom_range(0, 1), $urandom_range(0, 1),
            $urandom_range(0, 'hFFFF), pt, at);
    end

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
